// File: rtl/hall_commutation_decoder_if.sv
// Hall decoder bus: filtered hall inputs and error clear in, sector/speed/status out.
interface hall_commutation_decoder_if #(
   parameter int unsigned PER_W = 20,
   parameter int unsigned POS_W = 16
);
   logic             hall_a;
   logic             hall_b;
   logic             hall_c;
   logic             err_clr;
   logic [2:0]       sector;
   logic             sector_vld;
   logic             dir;
   logic [POS_W-1:0] pos;         // two's-complement step count
   logic [PER_W-1:0] period;
   logic             period_vld;
   logic             stalled;
   logic             step_err;
   logic             err_sticky;

   // Driver side (hall filter / control)
   modport master (
      output hall_a, hall_b, hall_c, err_clr,
      input  sector, sector_vld, dir, pos, period, period_vld, stalled, step_err, err_sticky
   );

   // Decoder side
   modport slave (
      input  hall_a, hall_b, hall_c, err_clr,
      output sector, sector_vld, dir, pos, period, period_vld, stalled, step_err, err_sticky
   );
endinterface

// File: rtl/hall_commutation_decoder.sv
// Hall commutation decoder: maps hall codes to electrical sector, tracks direction,
// signed position and inter-transition period, and flags illegal codes and skipped steps.
module hall_commutation_decoder #(
   parameter int unsigned PER_W   = 20,
   parameter int unsigned POS_W   = 16,
   parameter int unsigned TIMEOUT = 1_000_000
) (
   input logic                      clk,
   input logic                      rst,
   hall_commutation_decoder_if.slave bus
);

   typedef enum logic [1:0] {StInit, StSync, StRun} state_e;

   localparam logic [PER_W-1:0] CntOne = {{(PER_W-1){1'b0}}, 1'b1};
   localparam logic [POS_W-1:0] PosOne = {{(POS_W-1){1'b0}}, 1'b1};
   localparam logic [PER_W-1:0] CntTo  = PER_W'(TIMEOUT);

   state_e           state_q, state_d;
   logic [2:0]       code, code_prev_q;
   logic [2:0]       new_sec, sec_inc, sec_dec;
   logic             legal, trans, fwd, rev;
   logic [2:0]       sector_q, sector_d;
   logic             sector_vld_q, sector_vld_d;
   logic             dir_q, dir_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [PER_W-1:0] period_q, period_d;
   logic             period_vld_q, period_vld_d;
   logic             stalled_q, stalled_d;
   logic             step_err_q, step_err_d;
   logic             err_sticky_q, err_sticky_d;
   logic [PER_W-1:0] cnt_q, cnt_d;

   assign code  = {bus.hall_a, bus.hall_b, bus.hall_c};
   assign trans = (code != code_prev_q);

   // Decode hall code to sector; 000 and 111 are illegal
   always_comb begin
      new_sec = 3'd0;
      legal   = 1'b1;
      unique case (code)
         3'b101:  new_sec = 3'd0;
         3'b100:  new_sec = 3'd1;
         3'b110:  new_sec = 3'd2;
         3'b010:  new_sec = 3'd3;
         3'b011:  new_sec = 3'd4;
         3'b001:  new_sec = 3'd5;
         default: legal   = 1'b0;
      endcase
   end

   // Neighbour sectors modulo 6 relative to the current sector
   always_comb begin
      sec_inc = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
      sec_dec = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
      fwd     = (new_sec == sec_inc);
      rev     = (new_sec == sec_dec);
   end

   // Next-state and output logic for the tracking FSM
   always_comb begin
      state_d      = state_q;
      sector_d     = sector_q;
      sector_vld_d = sector_vld_q;
      dir_d        = dir_q;
      pos_d        = pos_q;
      period_d     = period_q;
      period_vld_d = 1'b0;
      stalled_d    = stalled_q;
      step_err_d   = 1'b0;
      cnt_d        = cnt_q;
      unique case (state_q)
         StInit: begin
            cnt_d = '0;
            if (legal) begin
               sector_d     = new_sec;
               sector_vld_d = 1'b1;
               state_d      = StSync;
            end
         end
         StSync, StRun: begin
            if (!trans) begin
               cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;
               // cnt runs on past TIMEOUT, so the stall fires only once per idle stretch
               if (cnt_q == CntTo) begin
                  stalled_d = 1'b1;
                  period_d  = '1;
                  state_d   = StSync;
               end
            end else if (!legal) begin
               step_err_d   = 1'b1;
               sector_vld_d = 1'b0;
               cnt_d        = '0;
               state_d      = StInit;
            end else if (fwd || rev) begin
               sector_d = new_sec;
               dir_d    = fwd;
               pos_d    = fwd ? pos_q + PosOne : pos_q - PosOne;
               cnt_d    = '0;
               // Only RUN has a previous valid edge to measure from
               if (state_q == StRun) begin
                  period_d     = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;
                  period_vld_d = 1'b1;
                  stalled_d    = 1'b0;
               end
               state_d = StRun;
            end else begin
               step_err_d = 1'b1;
               sector_d   = new_sec;
               cnt_d      = '0;
               state_d    = StSync;
            end
         end
         default: state_d = StInit;
      endcase
      // A new error wins over a simultaneous clear
      err_sticky_d = step_err_d | (err_sticky_q & ~bus.err_clr);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StInit;
         code_prev_q  <= 3'b000;
         sector_q     <= 3'd0;
         sector_vld_q <= 1'b0;
         dir_q        <= 1'b0;
         pos_q        <= '0;
         period_q     <= '1;
         period_vld_q <= 1'b0;
         stalled_q    <= 1'b1;
         step_err_q   <= 1'b0;
         err_sticky_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         code_prev_q  <= code;
         sector_q     <= sector_d;
         sector_vld_q <= sector_vld_d;
         dir_q        <= dir_d;
         pos_q        <= pos_d;
         period_q     <= period_d;
         period_vld_q <= period_vld_d;
         stalled_q    <= stalled_d;
         step_err_q   <= step_err_d;
         err_sticky_q <= err_sticky_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.sector     = sector_q;
   assign bus.sector_vld = sector_vld_q;
   assign bus.dir        = dir_q;
   assign bus.pos        = pos_q;
   assign bus.period     = period_q;
   assign bus.period_vld = period_vld_q;
   assign bus.stalled    = stalled_q;
   assign bus.step_err   = step_err_q;
   assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_hall_commutation_decoder.sv
// Directed bench for hall_commutation_decoder; period and step_err pulses are
// checked against expectations queued when the stimulus is applied.
module tb_hall_commutation_decoder;

   localparam int unsigned PER_W   = 20;
   localparam int unsigned POS_W   = 16;
   localparam int unsigned TIMEOUT = 1000;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   per_q[$];
   int   err_q[$];

   hall_commutation_decoder_if #(.PER_W(PER_W), .POS_W(POS_W)) bus ();

   hall_commutation_decoder #(
      .PER_W  (PER_W),
      .POS_W  (POS_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive a code, queue expected pulses, hold for 'hold' rising edges
   task automatic step(input logic [2:0] code, input int hold, input int exp_per,
                       input int exp_err_sec);
      @(negedge clk);
      if (exp_per >= 0) per_q.push_back(exp_per);
      if (exp_err_sec >= 0) err_q.push_back(exp_err_sec);
      {bus.hall_a, bus.hall_b, bus.hall_c} = code;
      repeat (hold) @(posedge clk);
      #1;
   endtask

   // Scoreboard: every output pulse must match a queued expectation
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.period_vld) begin
            chk("period_vld_expected", 32'(per_q.size() != 0), 32'd1);
            if (per_q.size() != 0) chk("period", 32'(bus.period), 32'(per_q.pop_front()));
         end
         if (bus.step_err) begin
            chk("step_err_expected", 32'(err_q.size() != 0), 32'd1);
            if (err_q.size() != 0) begin
               chk("err_sector", 32'(bus.sector), 32'(err_q.pop_front()));
               chk("err_sticky_set", 32'(bus.err_sticky), 32'd1);
            end
         end
      end
   end

   logic [2:0] fwd_codes [6];

   initial begin
      tests = 0;
      fails = 0;
      fwd_codes[0] = 3'b100;
      fwd_codes[1] = 3'b110;
      fwd_codes[2] = 3'b010;
      fwd_codes[3] = 3'b011;
      fwd_codes[4] = 3'b001;
      fwd_codes[5] = 3'b101;
      rst = 1'b1;
      bus.err_clr = 1'b0;
      {bus.hall_a, bus.hall_b, bus.hall_c} = 3'b101;

      // 1) reset values, then lock onto 101
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_sector", 32'(bus.sector), 32'd0);
      chk("rst_sector_vld", 32'(bus.sector_vld), 32'd0);
      chk("rst_dir", 32'(bus.dir), 32'd0);
      chk("rst_pos", 32'(bus.pos), 32'd0);
      chk("rst_period", 32'(bus.period), 32'hFFFFF);
      chk("rst_period_vld", 32'(bus.period_vld), 32'd0);
      chk("rst_stalled", 32'(bus.stalled), 32'd1);
      chk("rst_step_err", 32'(bus.step_err), 32'd0);
      chk("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
      rst = 1'b0;
      step(3'b101, 5, -1, -1);
      chk("t1_sector", 32'(bus.sector), 32'd0);
      chk("t1_sector_vld", 32'(bus.sector_vld), 32'd1);
      chk("t1_stalled", 32'(bus.stalled), 32'd1);
      chk("t1_period", 32'(bus.period), 32'hFFFFF);
      chk("t1_pos", 32'(bus.pos), 32'd0);

      // 2) full forward revolution, 100 clk per step
      for (int i = 0; i < 6; i++) begin
         step(fwd_codes[i], 100, (i == 0) ? -1 : 100, -1);
         chk("t2_sector", 32'(bus.sector), 32'((i + 1) % 6));
         chk("t2_pos", 32'(bus.pos), 32'(i + 1));
      end
      chk("t2_dir", 32'(bus.dir), 32'd1);
      chk("t2_stalled", 32'(bus.stalled), 32'd0);

      // 3) reset mid-run, then reverse at 50 clk per step
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t3_async_pos", 32'(bus.pos), 32'd0);
      chk("t3_async_period", 32'(bus.period), 32'hFFFFF);
      chk("t3_async_stalled", 32'(bus.stalled), 32'd1);
      chk("t3_async_dir", 32'(bus.dir), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(3'b101, 5, -1, -1);
      step(3'b001, 50, -1, -1);
      chk("t3_sector5", 32'(bus.sector), 32'd5);
      step(3'b011, 50, 50, -1);
      chk("t3_dir", 32'(bus.dir), 32'd0);
      chk("t3_pos", 32'(bus.pos), 32'hFFFE);
      chk("t3_sector4", 32'(bus.sector), 32'd4);
      chk("t3_sticky_clear", 32'(bus.err_sticky), 32'd0);

      // 4) illegal 111 with a simultaneous err_clr: error wins
      @(negedge clk);
      err_q.push_back(4);
      {bus.hall_a, bus.hall_b, bus.hall_c} = 3'b111;
      bus.err_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.err_clr = 1'b0;
      chk("t4_sticky_set_wins", 32'(bus.err_sticky), 32'd1);
      chk("t4_sector_vld", 32'(bus.sector_vld), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_hold_sector", 32'(bus.sector), 32'd4);
      step(3'b011, 5, -1, -1);
      chk("t4_relock_vld", 32'(bus.sector_vld), 32'd1);
      chk("t4_relock_sticky", 32'(bus.err_sticky), 32'd1);
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      #1;
      chk("t4_err_clr", 32'(bus.err_sticky), 32'd0);

      // 5) skip 101 -> 110 while running
      step(3'b001, 20, -1, -1);
      step(3'b101, 20, 20, -1);
      chk("t5_pos_before", 32'(bus.pos), 32'd0);
      step(3'b110, 20, -1, 2);
      chk("t5_skip_pos", 32'(bus.pos), 32'd0);
      chk("t5_skip_dir", 32'(bus.dir), 32'd1);
      chk("t5_skip_sector", 32'(bus.sector), 32'd2);
      step(3'b010, 30, -1, -1);
      chk("t5_resync_pos", 32'(bus.pos), 32'd1);
      step(3'b011, 30, 30, -1);
      chk("t5_run_pos", 32'(bus.pos), 32'd2);
      chk("t5_stalled", 32'(bus.stalled), 32'd0);

      // 6) stall after TIMEOUT idle cycles in RUN, then recover
      repeat (1000) @(posedge clk);
      #1;
      chk("t6_stalled", 32'(bus.stalled), 32'd1);
      chk("t6_period", 32'(bus.period), 32'hFFFFF);
      step(3'b001, 40, -1, -1);
      chk("t6_sync_period", 32'(bus.period), 32'hFFFFF);
      step(3'b101, 40, 40, -1);
      chk("t6_run_stalled", 32'(bus.stalled), 32'd0);
      chk("t6_pos", 32'(bus.pos), 32'd4);

      @(negedge clk);
      chk("per_q_drained", 32'(per_q.size()), 32'd0);
      chk("err_q_drained", 32'(err_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
